// File: rtl/ks_voice_sched_pkg.sv
// Shared types and defaults for the Karplus-Strong voice scheduler.
// Optional voice stealing is enabled by defining KS_SCHED_STEAL_EN.
package ks_pkg;
    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PLUCK_HOLD = 4;
    localparam int DEF_SUSTAIN_W  = 16;

    localparam int IDX_W  = $clog2(DEF_NUM_VOICES);
    localparam int HOLD_W = $clog2(DEF_PLUCK_HOLD + 1);

    localparam logic [DEF_DATA_WIDTH-1:0] PERIOD_DEFAULT = '1;

    typedef enum logic [1:0] {
        IDLE,
        PLUCK_HI,
        PLUCK_LO,
        ACTIVE
    } voice_state_e;

    function automatic int hold_w(input int hold);
        return $clog2(hold + 1);
    endfunction
endpackage

// File: rtl/ks_voice_sched_if.sv
// Note-request / allocation / voice-drive bundle of the voice scheduler.
interface ks_voice_sched_if #(
    parameter int NUM_VOICES = ks_pkg::DEF_NUM_VOICES,
    parameter int DATA_WIDTH = ks_pkg::DEF_DATA_WIDTH,
    parameter int SUSTAIN_W  = ks_pkg::DEF_SUSTAIN_W
);
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic                             note_valid_i;
    logic                             note_ready_o;
    logic [DATA_WIDTH-1:0]            note_period_i;
    logic [SUSTAIN_W-1:0]             note_sustain_i;
    logic                             all_off_i;
    logic                             alloc_valid_o;
    logic [IW-1:0]                    alloc_idx_o;
    logic                             alloc_steal_o;
    logic [NUM_VOICES-1:0]            pluck_o;
    logic [NUM_VOICES*DATA_WIDTH-1:0] period_o;
    logic [NUM_VOICES-1:0]            voice_active_o;

    modport slave (
        input  note_valid_i, note_period_i, note_sustain_i, all_off_i,
        output note_ready_o, alloc_valid_o, alloc_idx_o, alloc_steal_o,
               pluck_o, period_o, voice_active_o
    );

    modport master (
        output note_valid_i, note_period_i, note_sustain_i, all_off_i,
        input  note_ready_o, alloc_valid_o, alloc_idx_o, alloc_steal_o,
               pluck_o, period_o, voice_active_o
    );
endinterface

// File: rtl/ks_voice_sched_slot.sv
// One string voice: pluck pulse, low guard, sustain countdown and latched period.
// Under KS_SCHED_STEAL_EN the remaining sustain is exported for steal selection.
module ks_voice_slot
    import ks_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PLUCK_HOLD = DEF_PLUCK_HOLD,
    parameter int SUSTAIN_W  = DEF_SUSTAIN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  all_off,
    input  logic [DATA_WIDTH-1:0] period_in,
    input  logic [SUSTAIN_W-1:0]  sustain_in,
    output logic                  busy,
`ifdef KS_SCHED_STEAL_EN
    output logic                  stealable,
    output logic [SUSTAIN_W-1:0]  remain,
`endif
    output logic                  pluck,
    output logic [DATA_WIDTH-1:0] period
);
    localparam int HW = hold_w(PLUCK_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(PLUCK_HOLD - 1);

    voice_state_e         state, state_nxt;
    logic [HW-1:0]        hold_cnt;
    logic [SUSTAIN_W-1:0] sus_cnt, sus_latch;
    logic                 off_pend;
    logic                 hold_done;

    assign hold_done = (hold_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A load always wins: from IDLE it is a fresh note, from ACTIVE a steal.
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = PLUCK_HI;
        end else begin
            case (state)
                PLUCK_HI: if (hold_done) state_nxt = PLUCK_LO;
                PLUCK_LO: if (hold_done) state_nxt = (off_pend || all_off) ? IDLE : ACTIVE;
                ACTIVE:   if (all_off || sus_cnt == '0) state_nxt = IDLE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
`ifdef KS_SCHED_STEAL_EN
        stealable = (state == ACTIVE);
`endif
    end

`ifdef KS_SCHED_STEAL_EN
    assign remain = sus_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            sus_cnt   <= '0;
            sus_latch <= '0;
            off_pend  <= 1'b0;
            pluck     <= 1'b0;
            period    <= PERIOD_DEFAULT;
        end else begin
            // Registered from the next state so the pin never glitches.
            pluck <= (state_nxt == PLUCK_HI);
            if (load) begin
                period    <= period_in;
                sus_latch <= sustain_in;
                hold_cnt  <= HOLD_LAST;
                off_pend  <= 1'b0;
            end else begin
                if (state != state_nxt) hold_cnt <= HOLD_LAST;
                else if (!hold_done)    hold_cnt <= hold_cnt - HW'(1);
                if (all_off && (state == PLUCK_HI || state == PLUCK_LO)) off_pend <= 1'b1;
                if (state_nxt == IDLE) off_pend <= 1'b0;
                if (state_nxt == ACTIVE && state != ACTIVE)  sus_cnt <= sus_latch;
                else if (state == ACTIVE && sus_cnt != '0)   sus_cnt <= sus_cnt - SUSTAIN_W'(1);
            end
        end
    end
endmodule

// File: rtl/ks_voice_sched.sv
// Note allocator and handshake in front of NUM_VOICES Karplus-Strong voices.
// Define KS_SCHED_STEAL_EN to let a new note evict the ACTIVE voice closest to expiry.
module ks_voice_sched
    import ks_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PLUCK_HOLD = DEF_PLUCK_HOLD,
    parameter int SUSTAIN_W  = DEF_SUSTAIN_W
) (
    input logic              clk_i,
    input logic              rst_ni,
    ks_voice_sched_if.slave  bus
);
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [NUM_VOICES-1:0]                 busy, load, pluck;
    logic [NUM_VOICES-1:0][DATA_WIDTH-1:0] period;
    logic [IW-1:0]                         idle_sel, sel;
    logic                                  any_idle, accept;
`ifdef KS_SCHED_STEAL_EN
    logic [NUM_VOICES-1:0]                 stealable;
    logic [NUM_VOICES-1:0][SUSTAIN_W-1:0]  remain;
    logic [SUSTAIN_W-1:0]                  best;
    logic [IW-1:0]                         steal_sel;
    logic                                  any_act;
`endif

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        ks_voice_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .PLUCK_HOLD (PLUCK_HOLD),
            .SUSTAIN_W  (SUSTAIN_W)
        ) u_slot (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .load       (load[v]),
            .all_off    (bus.all_off_i),
            .period_in  (bus.note_period_i),
            .sustain_in (bus.note_sustain_i),
            .busy       (busy[v]),
`ifdef KS_SCHED_STEAL_EN
            .stealable  (stealable[v]),
            .remain     (remain[v]),
`endif
            .pluck      (pluck[v]),
            .period     (period[v])
        );
        assign load[v] = accept && (sel == IW'(v));
    end

    always_comb begin
        any_idle = 1'b0;
        idle_sel = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!busy[v] && !any_idle) begin
                idle_sel = IW'(v);
                any_idle = 1'b1;
            end
        end
    end

`ifdef KS_SCHED_STEAL_EN
    // Strict '<' while scanning upward keeps the lowest index on a tie.
    always_comb begin
        any_act   = 1'b0;
        steal_sel = '0;
        best      = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (stealable[v] && (!any_act || remain[v] < best)) begin
                steal_sel = IW'(v);
                best      = remain[v];
                any_act   = 1'b1;
            end
        end
    end

    assign bus.note_ready_o = !bus.all_off_i && (any_idle || any_act);
    assign sel              = any_idle ? idle_sel : steal_sel;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) bus.alloc_steal_o <= 1'b0;
        else         bus.alloc_steal_o <= accept && !any_idle;
    end
`else
    assign bus.note_ready_o  = !bus.all_off_i && any_idle;
    assign sel               = idle_sel;
    assign bus.alloc_steal_o = 1'b0;
`endif

    assign accept = bus.note_valid_i && bus.note_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bus.alloc_valid_o <= 1'b0;
            bus.alloc_idx_o   <= '0;
        end else begin
            bus.alloc_valid_o <= accept;
            if (accept) bus.alloc_idx_o <= sel;
        end
    end

    assign bus.pluck_o        = pluck;
    assign bus.period_o       = period;
    assign bus.voice_active_o = busy;
endmodule

// File: tb/tb_ks_voice_sched.sv
// Directed bench for ks_voice_sched; steal expectations follow KS_SCHED_STEAL_EN.
module tb_ks_voice_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pl_cnt, act_cnt, n;

    always #5 clk = ~clk;

    ks_voice_sched_if bus ();

    ks_voice_sched dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        n = 0;
        while (bus.voice_active_o != '0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 64'(n < 400), 64'd1);
    endtask

    initial begin
        bus.note_valid_i   = 1'b0;
        bus.note_period_i  = '0;
        bus.note_sustain_i = '0;
        bus.all_off_i      = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pluck",  64'(bus.pluck_o), 64'h0);
        chk("rst_active", 64'(bus.voice_active_o), 64'h0);
        chk("rst_period", 64'(bus.period_o), 64'hFFFF_FFFF);
        chk("rst_alloc",  64'({bus.alloc_valid_o, bus.alloc_idx_o, bus.alloc_steal_o}), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 64'(bus.note_ready_o), 64'h1);

        // single note: period 100, sustain 50
        @(posedge clk); #1;
        bus.note_valid_i = 1'b1; bus.note_period_i = 8'd100; bus.note_sustain_i = 16'd50;
        @(posedge clk); #1 bus.note_valid_i = 1'b0;
        pl_cnt = 0; act_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.pluck_o[0]) pl_cnt++;
            if (bus.voice_active_o[0]) act_cnt++;
            if (i == 0) begin
                chk("n1_alloc", 64'({bus.alloc_valid_o, bus.alloc_idx_o, bus.alloc_steal_o}), 64'b1000);
                chk("n1_period", 64'(bus.period_o[7:0]), 64'd100);
                chk("n1_pluck_rise", 64'(bus.pluck_o), 64'h1);
            end
            if (i == 1) chk("n1_alloc_pulse", 64'(bus.alloc_valid_o), 64'h0);
            if (i == 4) chk("n1_pluck_fall", 64'(bus.pluck_o), 64'h0);
        end
        chk("n1_pluck_cycles",  64'(pl_cnt), 64'd4);
        chk("n1_active_cycles", 64'(act_cnt), 64'd59);
        chk("n1_period_hold",   64'(bus.period_o[7:0]), 64'd100);

        // four back-to-back notes, fifth is held off
        @(posedge clk); #1;
        bus.note_valid_i = 1'b1; bus.note_period_i = 8'd10; bus.note_sustain_i = 16'd5;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("b2b_alloc", 64'({bus.alloc_valid_o, bus.alloc_idx_o}), 64'(4 + k));
            bus.note_period_i = 8'(11 + k);
        end
        chk("b2b_ready_low", 64'(bus.note_ready_o), 64'h0);
        chk("b2b_pluck",     64'(bus.pluck_o), 64'hF);
        chk("b2b_active",    64'(bus.voice_active_o), 64'hF);
        chk("b2b_periods",   64'(bus.period_o), 64'h0D0C_0B0A);
        @(posedge clk); #1;
        chk("b2b_no_accept", 64'(bus.alloc_valid_o), 64'h0);
        chk("b2b_pluck0_lo", 64'(bus.pluck_o), 64'hE);
        bus.note_valid_i = 1'b0;
        wait_idle("b2b_idle_wait");

        // fill with sustains 100,30,80,30 then request once all are ACTIVE
        @(posedge clk); #1;
        bus.note_valid_i = 1'b1; bus.note_period_i = 8'd20; bus.note_sustain_i = 16'd100;
        @(posedge clk); #1 bus.note_period_i = 8'd21; bus.note_sustain_i = 16'd30;
        @(posedge clk); #1 bus.note_period_i = 8'd22; bus.note_sustain_i = 16'd80;
        @(posedge clk); #1 bus.note_period_i = 8'd23; bus.note_sustain_i = 16'd30;
        @(posedge clk); #1 bus.note_valid_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("fill_active", 64'(bus.voice_active_o), 64'hF);
        bus.note_valid_i = 1'b1; bus.note_period_i = 8'd55; bus.note_sustain_i = 16'd7;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (bus.alloc_valid_o) break;
        end
        bus.note_valid_i = 1'b0;
`ifdef KS_SCHED_STEAL_EN
        chk("full_wait", 64'(n), 64'd1);
        chk("full_steal", 64'(bus.alloc_steal_o), 64'h1);
`else
        chk("full_wait", 64'(n), 64'd30);
        chk("full_steal", 64'(bus.alloc_steal_o), 64'h0);
`endif
        chk("full_idx",    64'(bus.alloc_idx_o), 64'd1);
        chk("full_pluck",  64'(bus.pluck_o), 64'h2);
        chk("full_period", 64'(bus.period_o[15:8]), 64'd55);
        wait_idle("full_idle_wait");

        // all_off with voice 0 ACTIVE and voice 1 in PLUCK_HI
        @(posedge clk); #1;
        bus.note_valid_i = 1'b1; bus.note_period_i = 8'd70; bus.note_sustain_i = 16'd200;
        @(posedge clk); #1 bus.note_valid_i = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        bus.note_valid_i = 1'b1; bus.note_period_i = 8'd77; bus.note_sustain_i = 16'd3;
        @(posedge clk); #1;
        chk("off_alloc", 64'({bus.alloc_valid_o, bus.alloc_idx_o}), 64'b101);
        bus.all_off_i = 1'b1;
        #1;
        chk("off_ready_low", 64'(bus.note_ready_o), 64'h0);
        @(posedge clk); #1;
        chk("off_active",    64'(bus.voice_active_o), 64'h2);
        chk("off_no_accept", 64'(bus.alloc_valid_o), 64'h0);
        chk("off_pluck_hi",  64'(bus.pluck_o), 64'h2);
        bus.all_off_i = 1'b0; bus.note_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("off_pluck_last", 64'(bus.pluck_o), 64'h2);
        @(posedge clk); #1;
        chk("off_pluck_fall", 64'(bus.pluck_o), 64'h0);
        chk("off_guard",      64'(bus.voice_active_o), 64'h2);
        repeat (3) @(posedge clk);
        #1 chk("off_guard_end", 64'(bus.voice_active_o), 64'h2);
        @(posedge clk); #1;
        chk("off_idle", 64'(bus.voice_active_o), 64'h0);

        // reset in the middle of PLUCK_HI
        @(posedge clk); #1;
        bus.note_valid_i = 1'b1; bus.note_period_i = 8'd9; bus.note_sustain_i = 16'd1;
        @(posedge clk); #1;
        chk("mid_pluck", 64'(bus.pluck_o), 64'h1);
        rst_n = 1'b0; bus.note_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_pluck",  64'(bus.pluck_o), 64'h0);
        chk("mid_rst_active", 64'(bus.voice_active_o), 64'h0);
        chk("mid_rst_period", 64'(bus.period_o), 64'hFFFF_FFFF);
        chk("mid_rst_alloc",  64'(bus.alloc_valid_o), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
